// File: rtl/blk_xfer_seq.sv
// Block-transfer sequencer for LDM/STM.
// Takes one block-transfer instruction from decode. Steps through its register
// list in ascending order over a req/ack memory handshake. Computes the start
// address for IA/IB/DA/DB and the base writeback value. At completion it pulses
// writeback, pipeline flush and SPSR restore.
module blk_xfer_seq #(
  parameter int unsigned NREG   = 16,
  parameter int unsigned AW     = 32,
  parameter int unsigned PC_IDX = NREG - 1,
  parameter int unsigned IW     = $clog2(NREG),
  parameter int unsigned CW     = $clog2(NREG + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            i_start,
  input  logic            i_p,
  input  logic            i_u,
  input  logic            i_s,
  input  logic            i_l,
  input  logic            i_w,
  input  logic [NREG-1:0] i_reglist,
  input  logic [AW-1:0]   i_base,
  output logic            o_busy,
  output logic            o_mem_req,
  input  logic            i_mem_ack,
  output logic [AW-1:0]   o_mem_addr,
  output logic            o_mem_we,
  output logic [IW-1:0]   o_reg_idx,
  output logic            o_last,
  output logic            o_user_bank,
  output logic            o_wb_vld,
  output logic [AW-1:0]   o_wb_val,
  output logic            o_flushreq,
  output logic            o_spsr_res
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state_q;
  logic [1:0]      state_d;
  logic [NREG-1:0] list_q;
  logic [CW-1:0]   cnt_q;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   wb_val_q;
  logic            s_q;
  logic            l_q;
  logic            w_q;
  logic            we_q;
  logic            pc_q;

  logic            take_start;
  logic            beat_done;
  logic [CW-1:0]   start_cnt;
  logic [AW-1:0]   span;
  logic [AW-1:0]   start_addr;
  logic [AW-1:0]   start_wb;
  logic [IW-1:0]   low_idx;

  // Accept a new instruction only in IDLE with a non-empty list; beats advance only on an enabled ack
  always_comb begin
    take_start = en & i_start & (state_q == S_IDLE) & (|i_reglist);
    beat_done  = en & i_mem_ack & (state_q == S_XFER);
  end

  // Transfer count plus the start address and writeback value for the incoming instruction
  always_comb begin
    start_cnt = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      start_cnt = start_cnt + CW'(i_reglist[i]);
    end
    span = AW'(start_cnt) << 2;
    case ({i_p, i_u})
      2'b01:   start_addr = i_base;                      // IA
      2'b11:   start_addr = i_base + AW'(4);             // IB
      2'b00:   start_addr = i_base - span + AW'(4);      // DA
      default: start_addr = i_base - span;               // DB
    endcase
    start_wb = i_u ? (i_base + span) : (i_base - span);
  end

  // Lowest set bit of the remaining list selects the register for the current beat
  always_comb begin
    low_idx = '0;
    for (int i = int'(NREG) - 1; i >= 0; i--) begin
      if (list_q[i]) begin
        low_idx = IW'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; DONE lasts exactly one enabled cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (take_start) begin
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (beat_done && (cnt_q == CW'(1))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (en) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latched instruction fields, remaining list, beat counter and running address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      list_q   <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wb_val_q <= '0;
      s_q      <= 1'b0;
      l_q      <= 1'b0;
      w_q      <= 1'b0;
      we_q     <= 1'b0;
      pc_q     <= 1'b0;
    end else if (take_start) begin
      list_q   <= i_reglist;
      cnt_q    <= start_cnt;
      addr_q   <= start_addr;
      wb_val_q <= start_wb;
      s_q      <= i_s;
      l_q      <= i_l;
      w_q      <= i_w;
      we_q     <= ~i_l;
      pc_q     <= i_reglist[PC_IDX];
    end else if (beat_done) begin
      // x & (x-1) drops the lowest set bit, i.e. the register just transferred
      list_q <= list_q & (list_q - NREG'(1));
      cnt_q  <= cnt_q - CW'(1);
      addr_q <= addr_q + AW'(4);
    end
  end

  // Output decode; handshake and completion pulses are masked while the pipeline is frozen
  always_comb begin
    o_busy      = (state_q != S_IDLE);
    o_mem_req   = en & (state_q == S_XFER);
    o_mem_addr  = addr_q;
    o_mem_we    = we_q;
    o_reg_idx   = low_idx;
    o_last      = (state_q == S_XFER) & (cnt_q == CW'(1));
    o_user_bank = (state_q == S_XFER) & s_q & ~(l_q & pc_q);
    o_wb_val    = wb_val_q;
    o_wb_vld    = en & (state_q == S_DONE) & w_q;
    o_flushreq  = en & (state_q == S_DONE) & l_q & pc_q;
    o_spsr_res  = en & (state_q == S_DONE) & l_q & s_q & pc_q;
  end

endmodule
